// File: rtl/csr_exc_sched.sv
// csr_exc_sched: trap/interrupt/ERTN scheduler at the MEM->WB boundary of a
// dual-issue pipeline (slot A older, slot B younger). At most one event is
// accepted per cycle. The WB-stage CSR update and the fetch redirect are
// registered and stay asserted for one FLUSH cycle. The MEM stage is then
// ignored for DRAIN_CYC cycles while the flushed instructions clear.
module csr_exc_sched #(
   parameter int                   ECODE_W   = 7,
   parameter logic [ECODE_W-1:0]   INT_ECODE = 7'h40,
   parameter int                   DRAIN_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               mem_a_valid,
   input  logic               mem_b_valid,
   input  logic [31:0]        mem_pc_a,
   input  logic [31:0]        mem_pc_b,
   input  logic [ECODE_W-1:0] ecode_a,
   input  logic [ECODE_W-1:0] ecode_b,
   input  logic               badv_we_a,
   input  logic               badv_we_b,
   input  logic [31:0]        badv_a,
   input  logic [31:0]        badv_b,
   input  logic               ertn_b,
   input  logic               int_req,
   input  logic [31:0]        csr_era,
   input  logic [31:0]        csr_eentry,
   output logic               wb_flush,
   output logic [31:0]        wb_flush_pc,
   output logic               wb_ecode_we,
   output logic [ECODE_W-1:0] wb_ecode,
   output logic               wb_badv_we,
   output logic [31:0]        wb_badv,
   output logic               wb_era_we,
   output logic [31:0]        wb_era,
   output logic               wb_store_state,
   output logic               wb_restore_state,
   output logic               int_pending,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, FLUSH, DRAIN} state_t;

   state_t             state;
   logic [3:0]         drain_cnt;

   logic               any_valid;
   logic               irq;
   logic               ev_trap;
   logic               ev_int;
   logic               ev_ertn;
   logic [ECODE_W-1:0] ev_ecode;
   logic [31:0]        ev_era;
   logic               ev_badv_we;
   logic [31:0]        ev_badv;
   logic               take_int;

   assign any_valid = mem_a_valid | mem_b_valid;
   assign irq       = int_req | int_pending;
   assign busy      = (state != IDLE);
   // The interrupt is consumed only when a decision is actually made.
   assign take_int  = (state == IDLE) && !stall && ev_int;

   // Prioritised event selection from the MEM slots and the interrupt.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      ev_trap    = 1'b0;
      ev_int     = 1'b0;
      ev_ertn    = 1'b0;
      ev_ecode   = '0;
      ev_era     = '0;
      ev_badv_we = 1'b0;
      ev_badv    = '0;
      if (irq && any_valid) begin
         ev_trap  = 1'b1;
         ev_int   = 1'b1;
         ev_ecode = INT_ECODE;
         ev_era   = mem_a_valid ? mem_pc_a : mem_pc_b;
      end else if (mem_a_valid && ecode_a != '0) begin
         ev_trap    = 1'b1;
         ev_ecode   = ecode_a;
         ev_era     = mem_pc_a;
         ev_badv_we = badv_we_a;
         ev_badv    = badv_a;
      end else if (mem_b_valid && ecode_b != '0) begin
         ev_trap    = 1'b1;
         ev_ecode   = ecode_b;
         ev_era     = mem_pc_b;
         ev_badv_we = badv_we_b;
         ev_badv    = badv_b;
      end else if (mem_b_valid && ertn_b) begin
         ev_ertn = 1'b1;
      end
   end

   // Scheduler FSM with registered WB outputs and interrupt latch.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state            <= IDLE;
         drain_cnt        <= '0;
         int_pending      <= 1'b0;
         wb_flush         <= 1'b0;
         wb_flush_pc      <= '0;
         wb_ecode_we      <= 1'b0;
         wb_ecode         <= '0;
         wb_badv_we       <= 1'b0;
         wb_badv          <= '0;
         wb_era_we        <= 1'b0;
         wb_era           <= '0;
         wb_store_state   <= 1'b0;
         wb_restore_state <= 1'b0;
      end else begin
         int_pending <= take_int ? 1'b0 : (int_pending | int_req);
         if (!stall) begin
            case (state)
               IDLE: begin
                  if (ev_trap) begin
                     state          <= FLUSH;
                     wb_flush       <= 1'b1;
                     wb_flush_pc    <= csr_eentry;
                     wb_ecode_we    <= 1'b1;
                     wb_ecode       <= ev_ecode;
                     wb_era_we      <= 1'b1;
                     wb_era         <= ev_era;
                     wb_badv_we     <= ev_badv_we;
                     wb_badv        <= ev_badv;
                     wb_store_state <= 1'b1;
                  end else if (ev_ertn) begin
                     state            <= FLUSH;
                     wb_flush         <= 1'b1;
                     wb_flush_pc      <= csr_era;
                     wb_restore_state <= 1'b1;
                  end
               end
               FLUSH: begin
                  state            <= DRAIN;
                  drain_cnt        <= 4'(DRAIN_CYC - 1);
                  wb_flush         <= 1'b0;
                  wb_ecode_we      <= 1'b0;
                  wb_badv_we       <= 1'b0;
                  wb_era_we        <= 1'b0;
                  wb_store_state   <= 1'b0;
                  wb_restore_state <= 1'b0;
               end
               DRAIN: begin
                  if (drain_cnt == '0) state <= IDLE;
                  else                 drain_cnt <= drain_cnt - 4'd1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_csr_exc_sched.sv
// Bench for csr_exc_sched: a table of single-cycle MEM-stage events with
// expected WB results (queued when driven, compared one edge later), then
// hand-written sequences for interrupt holding, drain, stall and reset.
module tb_csr_exc_sched;

   localparam int DRAIN_CYC = 2;
   localparam logic [31:0] EENTRY = 32'h1c008000;
   localparam logic [31:0] ERA    = 32'h1c000200;

   logic        clk = 1'b0;
   logic        rst, stall;
   logic        mem_a_valid, mem_b_valid;
   logic [31:0] mem_pc_a, mem_pc_b;
   logic [6:0]  ecode_a, ecode_b;
   logic        badv_we_a, badv_we_b;
   logic [31:0] badv_a, badv_b;
   logic        ertn_b, int_req;
   logic [31:0] csr_era, csr_eentry;
   logic        wb_flush;
   logic [31:0] wb_flush_pc;
   logic        wb_ecode_we;
   logic [6:0]  wb_ecode;
   logic        wb_badv_we;
   logic [31:0] wb_badv;
   logic        wb_era_we;
   logic [31:0] wb_era;
   logic        wb_store_state, wb_restore_state;
   logic        int_pending, busy;

   int total = 0;
   int bad   = 0;

   csr_exc_sched #(.ECODE_W(7), .INT_ECODE(7'h40), .DRAIN_CYC(DRAIN_CYC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .mem_a_valid(mem_a_valid), .mem_b_valid(mem_b_valid),
      .mem_pc_a(mem_pc_a), .mem_pc_b(mem_pc_b),
      .ecode_a(ecode_a), .ecode_b(ecode_b),
      .badv_we_a(badv_we_a), .badv_we_b(badv_we_b),
      .badv_a(badv_a), .badv_b(badv_b),
      .ertn_b(ertn_b), .int_req(int_req),
      .csr_era(csr_era), .csr_eentry(csr_eentry),
      .wb_flush(wb_flush), .wb_flush_pc(wb_flush_pc),
      .wb_ecode_we(wb_ecode_we), .wb_ecode(wb_ecode),
      .wb_badv_we(wb_badv_we), .wb_badv(wb_badv),
      .wb_era_we(wb_era_we), .wb_era(wb_era),
      .wb_store_state(wb_store_state), .wb_restore_state(wb_restore_state),
      .int_pending(int_pending), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        a_valid, b_valid;
      logic [31:0] pc_a, pc_b;
      logic [6:0]  ec_a, ec_b;
      logic        bwe_a, bwe_b;
      logic [31:0] bv_a, bv_b;
      logic        ertn, irq;
      // expected WB results one edge later
      logic        x_flush;
      logic [31:0] x_pc;
      logic        x_ecode_we;
      logic [6:0]  x_ecode;
      logic        x_badv_we;
      logic [31:0] x_badv;
      logic        x_era_we;
      logic [31:0] x_era;
      logic        x_store, x_restore;
   } vec_t;

   vec_t vecs[8];
   vec_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      mem_a_valid = 0; mem_b_valid = 0;
      mem_pc_a = '0; mem_pc_b = '0;
      ecode_a = '0; ecode_b = '0;
      badv_we_a = 0; badv_we_b = 0;
      badv_a = '0; badv_b = '0;
      ertn_b = 0; int_req = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         step();
         n++;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic apply_vec(input vec_t v);
      vec_t e;
      int   n;
      mem_a_valid = v.a_valid; mem_b_valid = v.b_valid;
      mem_pc_a = v.pc_a; mem_pc_b = v.pc_b;
      ecode_a = v.ec_a; ecode_b = v.ec_b;
      badv_we_a = v.bwe_a; badv_we_b = v.bwe_b;
      badv_a = v.bv_a; badv_b = v.bv_b;
      ertn_b = v.ertn; int_req = v.irq;
      sb_q.push_back(v);
      step();
      clear_inputs();
      e = sb_q.pop_front();
      check({e.name, ".flush"},   {31'b0, wb_flush},         {31'b0, e.x_flush});
      check({e.name, ".ecode_we"},{31'b0, wb_ecode_we},      {31'b0, e.x_ecode_we});
      check({e.name, ".badv_we"}, {31'b0, wb_badv_we},       {31'b0, e.x_badv_we});
      check({e.name, ".era_we"},  {31'b0, wb_era_we},        {31'b0, e.x_era_we});
      check({e.name, ".store"},   {31'b0, wb_store_state},   {31'b0, e.x_store});
      check({e.name, ".restore"}, {31'b0, wb_restore_state}, {31'b0, e.x_restore});
      check({e.name, ".int_pend"},{31'b0, int_pending},      32'd0);
      if (e.x_flush)    check({e.name, ".flush_pc"}, wb_flush_pc, e.x_pc);
      if (e.x_ecode_we) check({e.name, ".ecode"}, {25'b0, wb_ecode}, {25'b0, e.x_ecode});
      if (e.x_badv_we)  check({e.name, ".badv"}, wb_badv, e.x_badv);
      if (e.x_era_we)   check({e.name, ".era"}, wb_era, e.x_era);
      if (e.x_flush) begin
         n = 0;
         while (busy && n < 20) begin
            n++;
            step();
            if (n == 1) check({e.name, ".flush_one_cycle"}, {31'b0, wb_flush}, 32'd0);
         end
         check({e.name, ".busy_cycles"}, 32'(n), 32'(1 + DRAIN_CYC));
      end else begin
         check({e.name, ".stay_idle"}, {31'b0, busy}, 32'd0);
      end
   endtask

   initial begin
      //          name        aV bV pc_a          pc_b          ec_a   ec_b   bwa bwb bv_a   bv_b          ertn irq | flush pc     ecwe ecode badvwe badv   erawe era           st rs
      vecs[0] = '{"a_trap",   1, 0, 32'h1c000010, 32'h1c000014, 7'h08, 7'h00, 0, 0, 32'h0, 32'h0,        0,   0,   1, EENTRY, 1, 7'h08, 0, 32'h0, 1, 32'h1c000010, 1, 0};
      vecs[1] = '{"a_over_b", 1, 1, 32'h1c000020, 32'h1c000024, 7'h09, 7'h00, 1, 0, 32'h3, 32'h0,        1,   0,   1, EENTRY, 1, 7'h09, 1, 32'h3, 1, 32'h1c000020, 1, 0};
      vecs[2] = '{"b_trap",   0, 1, 32'h1c000030, 32'h1c000034, 7'h00, 7'h0b, 0, 1, 32'h0, 32'hdeadbeef, 0,   0,   1, EENTRY, 1, 7'h0b, 1, 32'hdeadbeef, 1, 32'h1c000034, 1, 0};
      vecs[3] = '{"ertn",     1, 1, 32'h1c000040, 32'h1c000044, 7'h00, 7'h00, 0, 0, 32'h0, 32'h0,        1,   0,   1, ERA,    0, 7'h00, 0, 32'h0, 0, 32'h0,        0, 1};
      vecs[4] = '{"no_event", 1, 1, 32'h1c000050, 32'h1c000054, 7'h00, 7'h00, 0, 0, 32'h0, 32'h0,        0,   0,   0, 32'h0,  0, 7'h00, 0, 32'h0, 0, 32'h0,        0, 0};
      vecs[5] = '{"a_inval",  0, 1, 32'h1c000060, 32'h1c000064, 7'h05, 7'h0b, 1, 0, 32'h7, 32'h0,        0,   0,   1, EENTRY, 1, 7'h0b, 0, 32'h0, 1, 32'h1c000064, 1, 0};
      vecs[6] = '{"int_a",    1, 1, 32'h1c000070, 32'h1c000074, 7'h08, 7'h00, 1, 0, 32'h9, 32'h0,        0,   1,   1, EENTRY, 1, 7'h40, 0, 32'h0, 1, 32'h1c000070, 1, 0};
      vecs[7] = '{"int_b",    0, 1, 32'h1c000080, 32'h1c000084, 7'h00, 7'h00, 0, 0, 32'h0, 32'h0,        0,   1,   1, EENTRY, 1, 7'h40, 0, 32'h0, 1, 32'h1c000084, 1, 0};

      clear_inputs();
      stall = 0;
      csr_era = ERA;
      csr_eentry = EENTRY;
      rst = 1;
      step();
      step();
      rst = 0;
      check("reset.flush",    {31'b0, wb_flush},       32'd0);
      check("reset.flush_pc", wb_flush_pc,             32'd0);
      check("reset.era",      wb_era,                  32'd0);
      check("reset.badv",     wb_badv,                 32'd0);
      check("reset.we",       {28'b0, wb_ecode_we, wb_badv_we, wb_era_we, wb_store_state}, 32'd0);
      check("reset.pending",  {31'b0, int_pending},    32'd0);
      check("reset.busy",     {31'b0, busy},           32'd0);

      for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

      // interrupt pulse with no valid slot is held until A arrives
      int_req = 1;
      step();
      int_req = 0;
      check("irq_hold.pending", {31'b0, int_pending}, 32'd1);
      check("irq_hold.flush",   {31'b0, wb_flush},    32'd0);
      step();
      step();
      check("irq_hold.still",   {31'b0, int_pending}, 32'd1);
      mem_a_valid = 1; mem_pc_a = 32'h1c000100;
      step();
      clear_inputs();
      check("irq_hold.take_flush", {31'b0, wb_flush},    32'd1);
      check("irq_hold.ecode",      {25'b0, wb_ecode},    32'h40);
      check("irq_hold.era",        wb_era,               32'h1c000100);
      check("irq_hold.cleared",    {31'b0, int_pending}, 32'd0);
      wait_idle();

      // B exception arriving during FLUSH/DRAIN is ignored
      mem_a_valid = 1; mem_pc_a = 32'h1c000110; ecode_a = 7'h08;
      step();
      clear_inputs();
      for (int n = 0; n < 20 && busy; n++) begin
         mem_b_valid = 1; mem_pc_b = 32'h1c000114; ecode_b = 7'h0b;
         step();
      end
      clear_inputs();
      check("drain_ignore.idle",  {31'b0, busy}, 32'd0);
      step();
      check("drain_ignore.flush", {31'b0, wb_flush}, 32'd0);
      check("drain_ignore.busy",  {31'b0, busy},     32'd0);

      // stall in FLUSH holds the flush; interrupt still captured
      mem_a_valid = 1; mem_pc_a = 32'h1c000120; ecode_a = 7'h08;
      step();
      clear_inputs();
      check("stall.flush0", {31'b0, wb_flush}, 32'd1);
      stall = 1; int_req = 1;
      step();
      int_req = 0;
      check("stall.flush1",  {31'b0, wb_flush},    32'd1);
      check("stall.pending", {31'b0, int_pending}, 32'd1);
      step();
      step();
      check("stall.flush3", {31'b0, wb_flush}, 32'd1);
      check("stall.era",    wb_era,            32'h1c000120);
      stall = 0;
      step();
      check("stall.released", {31'b0, wb_flush}, 32'd0);
      check("stall.busy",     {31'b0, busy},     32'd1);
      wait_idle();
      check("stall.pend_kept", {31'b0, int_pending}, 32'd1);
      mem_a_valid = 1; mem_pc_a = 32'h1c000300;
      step();
      clear_inputs();
      check("stall.int_ecode", {25'b0, wb_ecode},    32'h40);
      check("stall.int_era",   wb_era,               32'h1c000300);
      check("stall.int_clr",   {31'b0, int_pending}, 32'd0);
      wait_idle();

      // reset during DRAIN discards pending interrupt
      mem_a_valid = 1; mem_pc_a = 32'h1c000400; ecode_a = 7'h08;
      step();
      clear_inputs();
      int_req = 1;
      step();
      int_req = 0;
      check("rst_drain.busy",    {31'b0, busy},        32'd1);
      check("rst_drain.pending", {31'b0, int_pending}, 32'd1);
      rst = 1;
      step();
      rst = 0;
      check("rst_drain.idle",    {31'b0, busy},        32'd0);
      check("rst_drain.flags",   {26'b0, wb_flush, wb_ecode_we, wb_badv_we, wb_era_we, wb_store_state, wb_restore_state}, 32'd0);
      check("rst_drain.pend0",   {31'b0, int_pending}, 32'd0);
      check("rst_drain.era0",    wb_era,               32'd0);
      step();
      check("rst_drain.stay",    {30'b0, busy, int_pending}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
